// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer for the RV32 datapath: FETCH/DECODE/EXEC/MEM/WB
// with req/ack memory handshakes, a wait watchdog and a retire counter.
module core_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             br_taken,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             reg_we,
   output logic             busy,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_FAULT   = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   function automatic logic is_supported(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
         OP_STORE, OP_BR, OP_JAL, OP_JALR: is_supported = 1'b1;
         default:                          is_supported = 1'b0;
      endcase
   endfunction

   state_t           state_r;
   logic [6:0]       opcode_r;
   logic [1:0]       pc_sel_r;
   logic [7:0]       tmo_r;
   logic             fault_r;
   logic [CNT_W-1:0] retire_r;

   logic             imem_req_s;
   logic             dmem_req_s;
   logic             dmem_we_s;
   logic             ir_we_s;
   logic             pc_we_s;
   logic [1:0]       pc_sel_s;
   logic             reg_we_s;

   // Mealy strobe decode from current state, latched opcode and acks
   always_comb begin
      imem_req_s = 1'b0;
      dmem_req_s = 1'b0;
      dmem_we_s  = 1'b0;
      ir_we_s    = 1'b0;
      pc_we_s    = 1'b0;
      pc_sel_s   = 2'b00;
      reg_we_s   = 1'b0;
      case (state_r)
         S_FETCH: begin
            imem_req_s = 1'b1;
            if (imem_ack) ir_we_s = 1'b1;
            else          ir_we_s = 1'b0;
         end
         S_EXEC: begin
            if (opcode_r == OP_BR) begin
               pc_we_s  = 1'b1;
               pc_sel_s = br_taken ? 2'b01 : 2'b00;
            end else begin
               pc_we_s  = 1'b0;
            end
         end
         S_MEM: begin
            dmem_req_s = 1'b1;
            dmem_we_s  = (opcode_r == OP_STORE);
            if (dmem_ack && (opcode_r == OP_STORE)) pc_we_s = 1'b1;
            else                                    pc_we_s = 1'b0;
         end
         S_WB: begin
            reg_we_s = 1'b1;
            pc_we_s  = 1'b1;
            pc_sel_s = pc_sel_r;
         end
         default: pc_sel_s = 2'b00;
      endcase
   end

   // Strobes are forced low while reset is being sampled
   assign imem_req     = imem_req_s & ~reset;
   assign dmem_req     = dmem_req_s & ~reset;
   assign dmem_we      = dmem_we_s  & ~reset;
   assign ir_we        = ir_we_s    & ~reset;
   assign pc_we        = pc_we_s    & ~reset;
   assign pc_sel       = pc_sel_s   & {2{~reset}};
   assign reg_we       = reg_we_s   & ~reset;
   assign busy         = (state_r != S_IDLE) && (state_r != S_FAULT);
   assign fault        = fault_r;
   assign state        = state_r;
   assign retire_count = retire_r;

   // Sequencer state, watchdog, latched decode info and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         opcode_r <= 7'd0;
         pc_sel_r <= 2'b00;
         tmo_r    <= 8'd0;
         fault_r  <= 1'b0;
         retire_r <= '0;
      end else begin
         if (pc_we_s) retire_r <= retire_r + CNT_W'(1);
         else         retire_r <= retire_r;

         case (state_r)
            S_IDLE: begin
               tmo_r <= 8'd0;
               if (run) state_r <= S_FETCH;
               else     state_r <= S_IDLE;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  state_r <= S_DECODE;
               end else if (tmo_r == TMO_LAST) begin
                  state_r <= S_FAULT;
                  fault_r <= 1'b1;
               end else begin
                  tmo_r   <= tmo_r + 8'd1;
               end
            end
            S_DECODE: begin
               opcode_r <= opcode;
               if (is_supported(opcode)) begin
                  state_r <= S_EXEC;
               end else begin
                  state_r <= S_FAULT;
                  fault_r <= 1'b1;
               end
            end
            S_EXEC: begin
               case (opcode_r)
                  OP_LOAD, OP_STORE: begin
                     tmo_r   <= 8'd0;
                     state_r <= S_MEM;
                  end
                  OP_BR: begin
                     tmo_r   <= 8'd0;
                     state_r <= run ? S_FETCH : S_IDLE;
                  end
                  OP_JAL: begin
                     pc_sel_r <= 2'b01;
                     state_r  <= S_WB;
                  end
                  OP_JALR: begin
                     pc_sel_r <= 2'b10;
                     state_r  <= S_WB;
                  end
                  default: begin
                     pc_sel_r <= 2'b00;
                     state_r  <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  if (opcode_r == OP_STORE) begin
                     tmo_r   <= 8'd0;
                     state_r <= run ? S_FETCH : S_IDLE;
                  end else begin
                     pc_sel_r <= 2'b00;
                     state_r  <= S_WB;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  state_r <= S_FAULT;
                  fault_r <= 1'b1;
               end else begin
                  tmo_r   <= tmo_r + 8'd1;
               end
            end
            S_WB: begin
               tmo_r   <= 8'd0;
               state_r <= run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
               fault_r <= 1'b1;
               state_r <= S_FAULT;
            end
            default: begin
               fault_r <= 1'b1;
               state_r <= S_FAULT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-cycle expected traces are built from
// instruction-level rules (fetch/mem wait lengths, opcode class) and replayed.
module tb_core_sequencer;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct {
      logic        rst, run, iack, dack, br;
      logic [6:0]  opc;
      logic [2:0]  st;
      logic        ireq, dreq, dwe, irwe, pcwe, rwe, flt, chk;
      logic [1:0]  sel;
      logic [31:0] ret;
      logic [95:0] tag;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, run, br_taken, imem_ack, dmem_ack;
   logic [6:0]  opcode;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, busy, fault;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] retire_count;
   logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_reg_we, w_busy, w_fault;
   logic [1:0]  w_pc_sel;
   logic [2:0]  w_state;
   logic [1:0]  w_retire_count;

   vec_t        vq[$];
   logic [31:0] exp_retire = 32'd0;
   int          total = 0;
   int          bad = 0;
   logic [6:0]  ops[9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};

   always #5 clk = ~clk;

   core_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .br_taken(br_taken),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
      .busy(busy), .fault(fault), .state(state), .retire_count(retire_count));

   // narrow counter copy: exercises wrap-around of the retire counter
   core_sequencer #(.MEM_TIMEOUT(15), .CNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .br_taken(br_taken),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(w_imem_req), .dmem_req(w_dmem_req),
      .dmem_we(w_dmem_we), .ir_we(w_ir_we), .pc_we(w_pc_we), .pc_sel(w_pc_sel), .reg_we(w_reg_we),
      .busy(w_busy), .fault(w_fault), .state(w_state), .retire_count(w_retire_count));

   function automatic vec_t base(input logic [2:0] st, input logic [95:0] tag);
      vec_t v;
      v.rst = 1'b0; v.run = 1'($urandom); v.iack = 1'($urandom); v.dack = 1'($urandom);
      v.br = 1'($urandom); v.opc = 7'($urandom); v.st = st;
      v.ireq = 1'b0; v.dreq = 1'b0; v.dwe = 1'b0; v.irwe = 1'b0; v.pcwe = 1'b0; v.rwe = 1'b0;
      v.sel = 2'b00; v.flt = (st == 3'd6); v.chk = 1'b1; v.ret = exp_retire; v.tag = tag;
      return v;
   endfunction

   task automatic idle(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = base(3'd0, "idle"); v.run = 1'b0; vq.push_back(v);
      end
      v = base(3'd0, "idle_go"); v.run = 1'b1; vq.push_back(v);
   endtask

   task automatic rst_cycle();
      vec_t v;
      v = base(3'd0, "reset"); v.rst = 1'b1; v.chk = 1'b0; vq.push_back(v);
      exp_retire = 32'd0;
   endtask

   task automatic fault_hold(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = base(3'd6, "fault"); vq.push_back(v);
      end
   endtask

   task automatic fetch(input int fd);
      vec_t v;
      for (int i = 0; i < fd; i++) begin
         v = base(3'd1, "fetch_wait"); v.iack = 1'b0; v.ireq = 1'b1; vq.push_back(v);
      end
      v = base(3'd1, "fetch_ack"); v.iack = 1'b1; v.ireq = 1'b1; v.irwe = 1'b1; vq.push_back(v);
   endtask

   task automatic decode(input logic [6:0] op);
      vec_t v;
      v = base(3'd2, "decode"); v.opc = op; vq.push_back(v);
   endtask

   task automatic mem_wait(input logic [6:0] op, input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = base(3'd4, "mem_wait"); v.dack = 1'b0; v.dreq = 1'b1;
         v.dwe = (op == OP_STORE); vq.push_back(v);
      end
   endtask

   // one whole instruction from its first FETCH cycle to its boundary cycle
   task automatic instr(input logic [6:0] op, input int fd, input int md,
                        input logic br, input logic run_end);
      vec_t v;
      fetch(fd);
      decode(op);
      v = base(3'd3, "exec");
      if (op == OP_BR) begin
         v.br = br; v.pcwe = 1'b1; v.sel = br ? 2'b01 : 2'b00; v.run = run_end;
         vq.push_back(v); exp_retire++;
         return;
      end
      vq.push_back(v);
      if (op == OP_LOAD || op == OP_STORE) begin
         mem_wait(op, md);
         v = base(3'd4, "mem_ack"); v.dack = 1'b1; v.dreq = 1'b1; v.dwe = (op == OP_STORE);
         if (op == OP_STORE) begin
            v.pcwe = 1'b1; v.sel = 2'b00; v.run = run_end;
            vq.push_back(v); exp_retire++;
            return;
         end
         vq.push_back(v);
      end
      v = base(3'd5, "wb"); v.rwe = 1'b1; v.pcwe = 1'b1; v.run = run_end;
      v.sel = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
      vq.push_back(v); exp_retire++;
   endtask

   initial begin
      vec_t v;
      logic [8:0] a, e;
      logic       exp_busy;

      // directed scenarios
      rst_cycle(); idle(2);
      instr(OP_R, 1, 0, 1'b0, 1'b1);
      instr(OP_R, 1, 0, 1'b0, 1'b1);
      instr(OP_LOAD, 1, 3, 1'b0, 1'b1);
      instr(OP_STORE, 1, 3, 1'b0, 1'b1);
      instr(OP_BR, 0, 0, 1'b1, 1'b1);
      instr(OP_BR, 0, 0, 1'b0, 1'b1);
      instr(OP_JALR, 0, 0, 1'b0, 1'b1);
      instr(OP_JAL, 2, 0, 1'b0, 1'b1);
      instr(OP_LUI, 0, 0, 1'b0, 1'b1);
      instr(OP_AUIPC, 0, 0, 1'b0, 1'b1);
      instr(OP_I, 0, 0, 1'b0, 1'b1);
      instr(OP_LOAD, 0, 0, 1'b0, 1'b1);
      instr(OP_R, 1, 0, 1'b0, 1'b0);          // run dropped: completes WB then idles
      idle(3);
      // fetch watchdog: 15 FETCH cycles without ack, late ack ignored
      for (int i = 0; i < 15; i++) begin
         v = base(3'd1, "fetch_tmo"); v.iack = 1'b0; v.ireq = 1'b1; vq.push_back(v);
      end
      v = base(3'd6, "fault_iack"); v.iack = 1'b1; vq.push_back(v);
      fault_hold(3);
      rst_cycle(); idle(1);
      instr(OP_R, 14, 0, 1'b0, 1'b1);         // ack on the 15th fetch cycle
      instr(OP_STORE, 0, 14, 1'b0, 1'b1);     // ack on the 15th mem cycle
      // unsupported opcode
      fetch(1); decode(7'b0000000); fault_hold(3);
      rst_cycle(); idle(1);
      // data memory watchdog
      fetch(0); decode(OP_STORE);
      v = base(3'd3, "exec"); vq.push_back(v);
      mem_wait(OP_STORE, 15); fault_hold(2);
      rst_cycle(); idle(1);
      // reset mid-MEM
      instr(OP_R, 0, 0, 1'b0, 1'b1);
      fetch(1); decode(OP_LOAD);
      v = base(3'd3, "exec"); vq.push_back(v);
      mem_wait(OP_LOAD, 2);
      rst_cycle(); idle(2);
      // randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [6:0] op;
         logic       re;
         op = ops[$urandom_range(0, 8)];
         re = ($urandom_range(0, 3) != 0);
         instr(op, ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4),
               ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4), 1'($urandom), re);
         if (!re) idle($urandom_range(0, 3));
      end

      reset = 1'b1; run = 1'b0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = 7'd0;
      @(posedge clk); #1;
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         reset = v.rst; run = v.run; imem_ack = v.iack; dmem_ack = v.dack;
         br_taken = v.br; opcode = v.opc;
         #2;
         a = {imem_req, dmem_req, ir_we, pc_we, reg_we, (v.dreq ? dmem_we : 1'b0),
              (v.pcwe ? pc_sel : 2'b00), (pc_sel == 2'b11)};
         e = {v.ireq, v.dreq, v.irwe, v.pcwe, v.rwe, v.dwe, v.sel, 1'b0};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL strobes %s cyc=%0d got=%b want=%b", v.tag, i, a, e);
         end
         if (v.chk) begin
            exp_busy = (v.st != 3'd0) && (v.st != 3'd6);
            total++;
            if ({state, fault, busy} !== {v.st, v.flt, exp_busy}) begin
               bad++;
               $display("FAIL status %s cyc=%0d got st=%0d flt=%b busy=%b want st=%0d flt=%b busy=%b",
                        v.tag, i, state, fault, busy, v.st, v.flt, exp_busy);
            end
            total++;
            if (retire_count !== v.ret) begin
               bad++;
               $display("FAIL retire %s cyc=%0d got=%0d want=%0d", v.tag, i, retire_count, v.ret);
            end
            total++;
            if (w_retire_count !== v.ret[1:0]) begin
               bad++;
               $display("FAIL retire_wrap %s cyc=%0d got=%0d want=%0d", v.tag, i,
                        w_retire_count, v.ret[1:0]);
            end
         end
         @(posedge clk); #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
